// File: rtl/req_vector_serializer.sv
// Accepts a request vector over valid/ready and replays its set bits one beat
// at a time, lowest index first, as one-hot grant + binary index + last flag.
module req_vector_serializer #(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_onehot,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;

  logic             scan;
  logic [WIDTH-1:0] lowest;
  logic             in_fire;
  logic             out_fire;

  // Handshake: a transfer happens on an edge where valid and ready are both
  // high; valid never drops without a transfer, and ready may depend on the
  // opposite side's ready (in_ready follows out_ready on the final beat).
  always_comb begin
    scan       = (state_q == SCAN);
    lowest     = pending_q & (~pending_q + WIDTH'(1));
    out_valid  = scan;
    busy       = scan;
    out_onehot = scan ? lowest : '0;
    out_last   = scan && ((pending_q & ~lowest) == '0);
    out_idx    = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (out_onehot[i]) out_idx = IDX_W'(i);
    end
    out_fire   = out_valid && out_ready;
    in_ready   = !scan || (out_fire && out_last);
    in_fire    = in_valid && in_ready;
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    if (out_fire) begin
      pending_d = pending_q & ~lowest;
      if (out_last) state_d = IDLE;
    end
    // A new vector overrides the retiring beat; an all-zero vector is dropped.
    if (in_fire) begin
      if (in_vec != '0) begin
        pending_d = in_vec;
        state_d   = SCAN;
      end else begin
        state_d   = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_req_vector_serializer.sv
// Directed bench for req_vector_serializer: inputs change and outputs are
// checked 1 time unit after each falling edge, clear of the rising edge.
module tb_req_vector_serializer;

  localparam int WIDTH = 4;
  localparam int IDX_W = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_onehot;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;

  req_vector_serializer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_vec     (in_vec),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .busy       (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_idle(input string tag);
    check({tag, ".out_valid"},  32'(out_valid),  32'd0);
    check({tag, ".busy"},       32'(busy),       32'd0);
    check({tag, ".in_ready"},   32'(in_ready),   32'd1);
    check({tag, ".out_onehot"}, 32'(out_onehot), 32'd0);
    check({tag, ".out_idx"},    32'(out_idx),    32'd0);
    check({tag, ".out_last"},   32'(out_last),   32'd0);
  endtask

  task automatic expect_beat(input string tag, input logic [WIDTH-1:0] oh,
                             input logic [IDX_W-1:0] idx, input logic last,
                             input logic rdy);
    check({tag, ".out_valid"},  32'(out_valid),  32'd1);
    check({tag, ".busy"},       32'(busy),       32'd1);
    check({tag, ".out_onehot"}, 32'(out_onehot), 32'(oh));
    check({tag, ".out_idx"},    32'(out_idx),    32'(idx));
    check({tag, ".out_last"},   32'(out_last),   32'(last));
    check({tag, ".in_ready"},   32'(in_ready),   32'(rdy));
  endtask

  // Drive inputs just after a falling edge, then let them settle.
  task automatic drive(input logic iv, input logic [WIDTH-1:0] vec, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    in_vec    = vec;
    out_ready = ordy;
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b0;
    #12;
    expect_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: 0110 -> idx1, idx2(last)
    drive(1'b1, 4'b0110, 1'b1);
    check("t1.accept_ready", 32'(in_ready), 32'd1);
    drive(1'b0, 4'b0000, 1'b1);
    expect_beat("t1.b0", 4'b0010, 2'd1, 1'b0, 1'b0);
    drive(1'b0, 4'b0000, 1'b1);
    expect_beat("t1.b1", 4'b0100, 2'd2, 1'b1, 1'b1);
    drive(1'b0, 4'b0000, 1'b1);
    expect_idle("t1.done");

    // 2: all ones -> 4 beats, last on idx3
    drive(1'b1, 4'b1111, 1'b1);
    for (int i = 0; i < WIDTH; i++) begin
      drive(1'b0, 4'b0000, 1'b1);
      expect_beat($sformatf("t2.b%0d", i), 4'(1 << i), 2'(i), (i == WIDTH - 1),
                  (i == WIDTH - 1));
    end
    drive(1'b0, 4'b0000, 1'b1);
    expect_idle("t2.done");

    // 3: 1010 with 3-cycle stall on first beat; offered vector is ignored
    drive(1'b1, 4'b1010, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'b0101, 1'b0);
      expect_beat($sformatf("t3.stall%0d", i), 4'b0010, 2'd1, 1'b0, 1'b0);
    end
    drive(1'b0, 4'b0000, 1'b1);
    expect_beat("t3.b0", 4'b0010, 2'd1, 1'b0, 1'b0);
    drive(1'b0, 4'b0000, 1'b1);
    expect_beat("t3.b1", 4'b1000, 2'd3, 1'b1, 1'b1);
    drive(1'b0, 4'b0000, 1'b1);
    expect_idle("t3.done");

    // 4: back-to-back 1000 then 0001 with no bubble
    drive(1'b1, 4'b1000, 1'b1);
    drive(1'b1, 4'b0001, 1'b1);
    expect_beat("t4.b0", 4'b1000, 2'd3, 1'b1, 1'b1);
    drive(1'b0, 4'b0000, 1'b1);
    expect_beat("t4.b1", 4'b0001, 2'd0, 1'b1, 1'b1);
    drive(1'b0, 4'b0000, 1'b1);
    expect_idle("t4.done");

    // 5: zero vector is swallowed
    drive(1'b1, 4'b0000, 1'b1);
    check("t5.accept_ready", 32'(in_ready), 32'd1);
    drive(1'b0, 4'b0000, 1'b1);
    expect_idle("t5.after");
    drive(1'b0, 4'b0000, 1'b1);
    expect_idle("t5.after2");

    // 6: reset mid-scan of 0111 after first beat
    drive(1'b1, 4'b0111, 1'b1);
    drive(1'b0, 4'b0000, 1'b1);
    expect_beat("t6.b0", 4'b0001, 2'd0, 1'b0, 1'b0);
    drive(1'b0, 4'b0000, 1'b1);
    expect_beat("t6.b1", 4'b0010, 2'd1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    expect_idle("t6.in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'b0000, 1'b1);
      expect_idle($sformatf("t6.post%0d", i));
    end
    drive(1'b1, 4'b0100, 1'b1);
    drive(1'b0, 4'b0000, 1'b1);
    expect_beat("t6.new", 4'b0100, 2'd2, 1'b1, 1'b1);
    drive(1'b0, 4'b0000, 1'b1);
    expect_idle("t6.done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
